ex_mem_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/flag_unit.sv | 18 +
 rtl/ex_mem_stage.sv | 79 +++++++
 tb/tb_ex_mem_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, flag struct, flag-update classification and datapath widths.
package cpu_pkg;
  localparam int DW = 16;
  localparam int RW = 4;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
    OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_BR, OP_PCS, OP_HLT
  } opcode_t;
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;
  typedef enum logic {ST_RUN, ST_HALTED} state_t;
  function automatic logic sets_all_flags(opcode_t op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
  function automatic logic sets_z_only(opcode_t op);
    return op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR;
  endfunction
endpackage

// File: rtl/flag_unit.sv
// flag_unit: architectural Z/V/N register, updated only by accepted flag-setting opcodes.
module flag_unit import cpu_pkg::*; #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  opcode_t       op,
  input  logic [DW-1:0] result,
  input  logic          ovfl,
  output flags_t        flags
);
  always_ff @(posedge clk) begin
    if (rst) flags <= '0;
    else if (accept && sets_all_flags(op)) flags <= '{z: result == '0, v: ovfl, n: result[DW-1]};
    else if (accept && sets_z_only(op)) flags.z <= result == '0;
  end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with stall/flush handling, flag unit and sticky halt FSM.
module ex_mem_stage import cpu_pkg::*; #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [3:0]    ex_ctrl,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_ovfl,
  input  logic [RW-1:0] ex_dst,
  input  logic          ex_wr_en,
  input  logic [DW-1:0] ex_store_data,
  input  logic          stall,
  input  logic          flush,
  output logic          mem_valid,
  output logic [3:0]    mem_ctrl,
  output logic [DW-1:0] mem_result,
  output logic [RW-1:0] mem_dst,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_store_data,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          halted
);
  state_t state_q, state_d;
  flags_t flags;
  opcode_t op;
  logic accept;
  assign op = opcode_t'(ex_ctrl);
  assign halted = state_q == ST_HALTED;
  assign accept = ex_valid & ~stall & ~flush & ~halted;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == ST_RUN && accept && op == OP_HLT) ? ST_HALTED : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else state_q <= state_d;
  end
  // Flush and halt both drop valid; stall only holds when nothing kills the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_ctrl       <= '0;
      mem_result     <= '0;
      mem_dst        <= '0;
      mem_wr_en      <= 1'b0;
      mem_store_data <= '0;
    end else if (halted || flush) begin
      mem_valid <= 1'b0;
      mem_wr_en <= 1'b0;
    end else if (accept) begin
      mem_valid      <= 1'b1;
      mem_ctrl       <= ex_ctrl;
      mem_result     <= ex_result;
      mem_dst        <= ex_dst;
      mem_wr_en      <= ex_wr_en && op != OP_HLT;
      mem_store_data <= ex_store_data;
    end else if (!stall) begin
      mem_valid <= 1'b0;
      mem_wr_en <= 1'b0;
    end
  end
  flag_unit #(.DW(DW)) u_flags (
    .clk(clk),
    .rst(rst),
    .accept(accept),
    .op(op),
    .result(ex_result),
    .ovfl(ex_ovfl),
    .flags(flags)
  );
  assign flag_z = flags.z;
  assign flag_v = flags.v;
  assign flag_n = flags.n;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed test-plan sequence then random stimulus against a behavioural model.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ex_valid, ex_ovfl, ex_wr_en, stall, flush;
  logic [3:0] ex_ctrl, ex_dst;
  logic [15:0] ex_result, ex_store_data;
  logic mem_valid, mem_wr_en, flag_z, flag_v, flag_n, halted;
  logic [3:0] mem_ctrl, mem_dst;
  logic [15:0] mem_result, mem_store_data;
  ex_mem_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_result(ex_result),
    .ex_ovfl(ex_ovfl), .ex_dst(ex_dst), .ex_wr_en(ex_wr_en), .ex_store_data(ex_store_data),
    .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_ctrl(mem_ctrl),
    .mem_result(mem_result), .mem_dst(mem_dst), .mem_wr_en(mem_wr_en),
    .mem_store_data(mem_store_data), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .halted(halted)
  );
  logic e_valid = 0, e_we = 0, e_z = 0, e_v = 0, e_n = 0, e_halt = 0, e_known = 0;
  logic [3:0] e_ctrl = 0, e_dst = 0;
  logic [15:0] e_res = 0, e_sd = 0;
  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference behaviour: what the stage should hold after one rising edge with the current inputs.
  task automatic model();
    if (rst) begin
      {e_valid, e_we, e_z, e_v, e_n, e_halt} = '0;
      e_ctrl = 0; e_dst = 0; e_res = 0; e_sd = 0; e_known = 1;
    end else if (e_halt || flush) begin
      e_valid = 0; e_we = 0; e_known = 0;
    end else if (stall) begin
    end else if (!ex_valid) begin
      e_valid = 0; e_we = 0; e_known = 0;
    end else begin
      e_valid = 1; e_known = 1;
      e_ctrl = ex_ctrl; e_res = ex_result; e_dst = ex_dst; e_sd = ex_store_data;
      e_we = ex_wr_en && ex_ctrl != 4'hF;
      if (ex_ctrl == 4'h0 || ex_ctrl == 4'h1) begin
        e_z = ex_result == 0; e_v = ex_ovfl; e_n = ex_result[15];
      end else if (ex_ctrl == 4'h2 || ex_ctrl == 4'h4 || ex_ctrl == 4'h5 || ex_ctrl == 4'h6)
        e_z = ex_result == 0;
      if (ex_ctrl == 4'hF) e_halt = 1;
    end
  endtask
  task automatic compare();
    check("mem_valid", mem_valid, e_valid);
    check("mem_wr_en", mem_wr_en, e_we);
    check("flag_z", flag_z, e_z);
    check("flag_v", flag_v, e_v);
    check("flag_n", flag_n, e_n);
    check("halted", halted, e_halt);
    if (e_known) begin
      check("mem_ctrl", mem_ctrl, e_ctrl);
      check("mem_result", mem_result, e_res);
      check("mem_dst", mem_dst, e_dst);
      check("mem_store_data", mem_store_data, e_sd);
    end
  endtask
  task automatic apply(input logic v, input logic [3:0] c, input logic [15:0] r, input logic o,
                       input logic [3:0] d, input logic w, input logic [15:0] s,
                       input logic st, input logic fl, input logic rs);
    ex_valid = v; ex_ctrl = c; ex_result = r; ex_ovfl = o; ex_dst = d;
    ex_wr_en = w; ex_store_data = s; stall = st; flush = fl; rst = rs;
    @(posedge clk);
    model();
    #1 compare();
  endtask
  initial begin
    logic [3:0] c;
    logic [15:0] r;
    apply(1, 4'h0, 16'h0005, 0, 4'h1, 1, 16'h0000, 0, 0, 1);
    apply(1, 4'h0, 16'h0005, 0, 4'h1, 1, 16'h0000, 0, 0, 1);
    check("reset_z_explicit", flag_z, 1'b0);
    apply(1, 4'h0, 16'h0000, 1, 4'h3, 1, 16'h1111, 0, 0, 0);
    check("add_zero_z", flag_z, 1'b1);
    apply(1, 4'h1, 16'h8001, 0, 4'h4, 1, 16'h2222, 0, 0, 0);
    check("sub_n", flag_n, 1'b1);
    apply(1, 4'h2, 16'h0000, 1, 4'h5, 1, 16'h3333, 0, 0, 0);
    check("xor_v_held", flag_v, 1'b0);
    for (int i = 0; i < 3; i++) apply(1, 4'h8, 16'h1234, 0, 4'h6, 1, 16'h0000, 1, 0, 0);
    check("stall_ctrl_held", mem_ctrl, 4'h2);
    apply(1, 4'h8, 16'h1234, 0, 4'h6, 1, 16'h0000, 0, 0, 0);
    check("lw_result", mem_result, 16'h1234);
    apply(1, 4'h0, 16'h0000, 0, 4'h7, 1, 16'h0000, 1, 1, 0);
    check("flush_valid", mem_valid, 1'b0);
    apply(1, 4'h0, 16'h8000, 0, 4'h7, 1, 16'h0000, 0, 0, 0);
    apply(1, 4'hF, 16'h0000, 0, 4'h0, 1, 16'h0000, 0, 0, 0);
    check("hlt_ctrl", mem_ctrl, 4'hF);
    for (int i = 0; i < 4; i++) apply(1, 4'h0, 16'h0000, 1, 4'h2, 1, 16'h0000, 0, 0, 0);
    check("halt_sticky", halted, 1'b1);
    apply(0, 4'h0, 16'h0000, 0, 4'h0, 0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      c = 4'($urandom);
      if (c == 4'hF && $urandom_range(3) != 0) c = 4'($urandom_range(14));
      r = ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom);
      apply($urandom_range(9) < 8, c, r, 1'($urandom), 4'($urandom), 1'($urandom),
            16'($urandom), $urandom_range(3) == 0, $urandom_range(7) == 0,
            $urandom_range(60) == 0 || (e_halt && $urandom_range(5) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
